// File: rtl/enigma_ctrl_if.sv
// Handshake and rotor-chain bundle for the Enigma sequencing controller.
// The slave modport is the controller's view; master is the host/rotor side.
interface enigma_ctrl_if;
    logic        cfg_valid;
    logic [14:0] cfg_offset;
    logic [14:0] cfg_ring;
    logic        cfg_ready;
    logic        in_valid;
    logic [7:0]  in_char;
    logic        in_ready;
    logic        out_valid;
    logic [7:0]  out_char;
    logic        out_ready;
    logic        rotor_set;
    logic [14:0] rotor_offset;
    logic [14:0] rotor_ring;
    logic        rotor_step0;
    logic        rotor_step;
    logic [25:0] letter_oh;
    logic [25:0] result_oh;
    logic        configured;
    logic        err;
    logic [15:0] letter_count;

    modport slave (
        input  cfg_valid, cfg_offset, cfg_ring, in_valid, in_char, out_ready, result_oh,
        output cfg_ready, in_ready, out_valid, out_char, rotor_set, rotor_offset,
               rotor_ring, rotor_step0, rotor_step, letter_oh, configured, err, letter_count
    );

    modport master (
        output cfg_valid, cfg_offset, cfg_ring, in_valid, in_char, out_ready, result_oh,
        input  cfg_ready, in_ready, out_valid, out_char, rotor_set, rotor_offset,
               rotor_ring, rotor_step0, rotor_step, letter_oh, configured, err, letter_count
    );
endinterface

// File: rtl/enigma_ctrl.sv
// Enigma sequencing controller: loads rotor configuration, steps the rotors
// once per letter, drives the one-hot letter into the chain, waits for the
// combinational path to settle and returns the encrypted ASCII character.
module enigma_ctrl #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic          clk,
    input  logic          reset,
    enigma_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {IDLE, LOAD, STEP, SETTLE, OUT} state_t;

    state_t      state_q;
    logic        configured_q;
    logic        err_q;
    logic [15:0] letterCount_q;
    logic        outValid_q;
    logic [7:0]  outChar_q;
    logic        rotorSet_q;
    logic        step_q;
    logic [25:0] letterOh_q;
    logic [14:0] offset_q;
    logic [14:0] ring_q;
    logic [4:0]  index_q;
    logic [3:0]  settleCnt_q;

    logic        isUpper;
    logic        isLower;
    logic        isLetter;
    logic [7:0]  charDiff;
    logic [4:0]  charIndex;
    logic [4:0]  resultCount;
    logic [4:0]  resultPos;
    logic        resultGood;
    logic        cfgAccept;
    logic        inAccept;

    // Classify the offered byte and fold both cases onto a 0..25 letter index
    always_comb begin
        isUpper   = (bus.in_char >= 8'h41) && (bus.in_char <= 8'h5A);
        isLower   = (bus.in_char >= 8'h61) && (bus.in_char <= 8'h7A);
        isLetter  = isUpper || isLower;
        charDiff  = isUpper ? (bus.in_char - 8'h41) : (bus.in_char - 8'h61);
        charIndex = charDiff[4:0];
    end

    // Count set bits of the chain output; only a single hit is a valid letter
    always_comb begin
        resultCount = 5'd0;
        resultPos   = 5'd0;
        for (int i = 0; i < 26; i++) begin
            if (bus.result_oh[i]) begin
                resultCount = resultCount + 5'd1;
                resultPos   = 5'(i);
            end
        end
        resultGood = (resultCount == 5'd1);
    end

    // Configuration always wins over a character offered in the same cycle
    assign cfgAccept     = (state_q == IDLE) && bus.cfg_valid;
    assign bus.cfg_ready = (state_q == IDLE);
    assign bus.in_ready  = (state_q == IDLE) && configured_q && !bus.cfg_valid;
    assign inAccept      = bus.in_valid && bus.in_ready;

    // Sequencer: all outputs are registered; pulses default low each cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            configured_q  <= 1'b0;
            err_q         <= 1'b0;
            letterCount_q <= 16'd0;
            outValid_q    <= 1'b0;
            outChar_q     <= 8'd0;
            rotorSet_q    <= 1'b0;
            step_q        <= 1'b0;
            letterOh_q    <= 26'd0;
            offset_q      <= 15'd0;
            ring_q        <= 15'd0;
            index_q       <= 5'd0;
            settleCnt_q   <= 4'd0;
        end else begin
            rotorSet_q <= 1'b0;
            step_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cfgAccept) begin
                        offset_q      <= bus.cfg_offset;
                        ring_q        <= bus.cfg_ring;
                        err_q         <= 1'b0;
                        letterCount_q <= 16'd0;
                        rotorSet_q    <= 1'b1;
                        state_q       <= LOAD;
                    end else if (inAccept) begin
                        if (isLetter) begin
                            index_q <= charIndex;
                            step_q  <= 1'b1;
                            state_q <= STEP;
                        end else begin
                            outChar_q  <= bus.in_char;
                            outValid_q <= 1'b1;
                            state_q    <= OUT;
                        end
                    end
                end
                LOAD: begin
                    configured_q <= 1'b1;
                    state_q      <= IDLE;
                end
                STEP: begin
                    letterOh_q  <= 26'd1 << index_q;
                    settleCnt_q <= 4'(SETTLE_CYCLES - 1);
                    state_q     <= SETTLE;
                end
                SETTLE: begin
                    if (settleCnt_q == 4'd0) begin
                        letterOh_q    <= 26'd0;
                        outValid_q    <= 1'b1;
                        outChar_q     <= resultGood ? (8'h41 + {3'b000, resultPos}) : 8'h3F;
                        err_q         <= err_q | !resultGood;
                        letterCount_q <= letterCount_q + 16'd1;
                        state_q       <= OUT;
                    end else begin
                        settleCnt_q <= settleCnt_q - 4'd1;
                    end
                end
                OUT: begin
                    if (bus.out_ready) begin
                        outValid_q <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.out_valid    = outValid_q;
    assign bus.out_char     = outChar_q;
    assign bus.rotor_set    = rotorSet_q;
    assign bus.rotor_offset = offset_q;
    assign bus.rotor_ring   = ring_q;
    assign bus.rotor_step0  = step_q;
    assign bus.rotor_step   = step_q;
    assign bus.letter_oh    = letterOh_q;
    assign bus.configured   = configured_q;
    assign bus.err          = err_q;
    assign bus.letter_count = letterCount_q;

endmodule

// File: tb/tb_enigma_ctrl.sv
// Bench for enigma_ctrl: models rotors I/II/III with reflector B as the
// rotor chain, and keeps an independent letter-level Enigma reference.
module tb_enigma_ctrl;
    localparam int S = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    enigma_ctrl_if bus();

    enigma_ctrl #(.SETTLE_CYCLES(S)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

    int nChecks = 0;
    int nFails  = 0;

    int fw[3][26];
    int bw[3][26];
    int refl[26];

    logic [14:0] cPos = 15'd0, cRing = 15'd0;
    logic [14:0] rPos = 15'd0, rRing = 15'd0;
    int          rCount = 0;
    bit          forceEn = 1'b0;
    logic [25:0] forceVal = 26'd0;

    logic [7:0] tGot;
    int tStepAt, tStepCnt, tRstepCnt, tOhCnt, tValidAt, tTimeout, tReadyAfter;
    int tHoldBad, tHoldReady, tHoldSteps;
    int tSetCnt, tSetAt, tCfgReadyBack;

    // Rotor wirings: index 0 = left (I), 1 = middle (II), 2 = right (III)
    initial begin
        string w[3];
        string rb;
        w[0] = "EKMFLGDQVZNTOWYHXUSPAIBRCJ";
        w[1] = "AJDKSIRUXBLHWTMCQGZNPYFVOE";
        w[2] = "BDFHJLCPRTXVZNYEIWGAKMOUSQ";
        rb   = "YRUHQSLDPXNGOKMIEBFZCWVJAT";
        for (int r = 0; r < 3; r++)
            for (int i = 0; i < 26; i++) begin
                fw[r][i] = int'(w[r][i]) - 65;
                bw[r][fw[r][i]] = i;
            end
        for (int i = 0; i < 26; i++) refl[i] = int'(rb[i]) - 65;
    end

    function automatic bit isAlpha(input logic [7:0] c);
        return (c >= 8'h41 && c <= 8'h5A) || (c >= 8'h61 && c <= 8'h7A);
    endfunction

    // One keypress of rotor motion, including the middle-rotor double step
    function automatic logic [14:0] stepPacked(input logic [14:0] p);
        int l, m, r;
        l = int'(p[14:10]); m = int'(p[9:5]); r = int'(p[4:0]);
        if (m == 4) begin
            m = (m + 1) % 26; l = (l + 1) % 26;
        end else if (r == 21) begin
            m = (m + 1) % 26;
        end
        r = (r + 1) % 26;
        return {5'(l), 5'(m), 5'(r)};
    endfunction

    function automatic int rotorPass(input int c, input int r, input int pos, input int rg, input bit back);
        int sh, x;
        sh = (pos - rg + 26) % 26;
        x  = (c + sh) % 26;
        x  = back ? bw[r][x] : fw[r][x];
        return (x - sh + 26) % 26;
    endfunction

    function automatic int encryptIdx(input int idx, input logic [14:0] pos, input logic [14:0] rg);
        int c;
        c = rotorPass(idx, 2, int'(pos[4:0]),   int'(rg[4:0]),   1'b0);
        c = rotorPass(c,   1, int'(pos[9:5]),   int'(rg[9:5]),   1'b0);
        c = rotorPass(c,   0, int'(pos[14:10]), int'(rg[14:10]), 1'b0);
        c = refl[c];
        c = rotorPass(c,   0, int'(pos[14:10]), int'(rg[14:10]), 1'b1);
        c = rotorPass(c,   1, int'(pos[9:5]),   int'(rg[9:5]),   1'b1);
        c = rotorPass(c,   2, int'(pos[4:0]),   int'(rg[4:0]),   1'b1);
        return c;
    endfunction

    task automatic refLoad(input logic [14:0] off, input logic [14:0] rg);
        rPos = off; rRing = rg; rCount = 0;
    endtask

    // Letter-level reference: what a real Enigma prints for this keypress
    function automatic logic [7:0] refChar(input logic [7:0] ch);
        int idx;
        if (!isAlpha(ch)) return ch;
        idx = (ch <= 8'h5A) ? int'(ch) - 65 : int'(ch) - 97;
        rPos = stepPacked(rPos);
        rCount++;
        return 8'(65 + encryptIdx(idx, rPos, rRing));
    endfunction

    // Rotor chain stand-in, reacting only to the controller's pulses
    always @(negedge clk) begin
        int li;
        if (bus.rotor_set) begin cPos = bus.rotor_offset; cRing = bus.rotor_ring; end
        if (bus.rotor_step0) cPos = stepPacked(cPos);
        if (forceEn) bus.result_oh = forceVal;
        else if ($onehot(bus.letter_oh)) begin
            li = 0;
            for (int i = 0; i < 26; i++) if (bus.letter_oh[i]) li = i;
            bus.result_oh = 26'd1 << encryptIdx(li, cPos, cRing);
        end else bus.result_oh = 26'd0;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "[TB] watchdog");
    end

    task automatic loadCfg(input logic [14:0] off, input logic [14:0] rg);
        int n = 0;
        tSetCnt = 0; tSetAt = -1; tCfgReadyBack = 0; tTimeout = 0;
        bus.cfg_valid = 1'b1; bus.cfg_offset = off; bus.cfg_ring = rg;
        while (!bus.cfg_ready && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) begin tTimeout = 1; bus.cfg_valid = 1'b0; return; end
        @(posedge clk); @(negedge clk);
        bus.cfg_valid = 1'b0;
        for (int rel = 1; rel <= 3; rel++) begin
            if (bus.rotor_set) begin tSetCnt++; tSetAt = rel; end
            if (rel == 2) tCfgReadyBack = int'(bus.cfg_ready && bus.in_ready);
            if (rel < 3) @(negedge clk);
        end
        refLoad(off, rg);
    endtask

    task automatic charTxn(input logic [7:0] ch, input int hold);
        int n = 0;
        tStepAt = -1; tStepCnt = 0; tRstepCnt = 0; tOhCnt = 0; tValidAt = -1; tTimeout = 0;
        tHoldBad = 0; tHoldReady = 0; tHoldSteps = 0; tGot = 8'h00; tReadyAfter = 0;
        bus.in_valid = 1'b1; bus.in_char = ch; bus.out_ready = 1'b0;
        while (!bus.in_ready && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) begin tTimeout = 1; bus.in_valid = 1'b0; return; end
        @(posedge clk); @(negedge clk);
        bus.in_valid = 1'b0;
        for (int rel = 1; rel < 60 && tValidAt < 0; rel++) begin
            if (bus.rotor_step0) begin tStepCnt++; tStepAt = rel; end
            if (bus.rotor_step) tRstepCnt++;
            if (bus.letter_oh != 26'd0) tOhCnt++;
            if (bus.out_valid) begin tValidAt = rel; tGot = bus.out_char; end
            else @(negedge clk);
        end
        if (tValidAt < 0) begin tTimeout = 1; return; end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (!bus.out_valid || bus.out_char !== tGot) tHoldBad++;
            if (bus.in_ready || bus.cfg_ready) tHoldReady++;
            if (bus.rotor_step0 || bus.rotor_step || bus.rotor_set) tHoldSteps++;
        end
        bus.out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.out_ready = 1'b0;
        tReadyAfter = int'(bus.in_ready);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.cfg_valid = 1'b0; bus.cfg_offset = 15'd0; bus.cfg_ring = 15'd0;
        bus.in_valid = 1'b0; bus.in_char = 8'd0; bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        nChecks++; if ({bus.cfg_ready, bus.in_ready, bus.out_valid} !== 3'b100) begin nFails++; $display("[TB] FAIL reset handshake: got %b required 100", {bus.cfg_ready, bus.in_ready, bus.out_valid}); end
        nChecks++; if ({bus.rotor_set, bus.rotor_step0, bus.rotor_step} !== 3'b000) begin nFails++; $display("[TB] FAIL reset pulses: got %b required 000", {bus.rotor_set, bus.rotor_step0, bus.rotor_step}); end
        nChecks++; if ({bus.out_char, bus.letter_oh, bus.rotor_offset, bus.rotor_ring} !== 64'd0) begin nFails++; $display("[TB] FAIL reset data: got %h required 0", {bus.out_char, bus.letter_oh, bus.rotor_offset, bus.rotor_ring}); end
        nChecks++; if ({bus.configured, bus.err, bus.letter_count} !== 18'd0) begin nFails++; $display("[TB] FAIL reset status: got %h required 0", {bus.configured, bus.err, bus.letter_count}); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_unconfigured_arbitration();
        logic [7:0] exp;
        int n = 0;
        int setSeen = 0;
        bus.in_valid = 1'b1; bus.in_char = 8'h41;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            nChecks++; if (bus.in_ready !== 1'b0) begin nFails++; $display("[TB] FAIL unconfigured in_ready: got %b required 0", bus.in_ready); end
        end
        bus.cfg_valid = 1'b1; bus.cfg_offset = 15'd0; bus.cfg_ring = 15'd0;
        nChecks++; if ({bus.cfg_ready, bus.in_ready} !== 2'b10) begin nFails++; $display("[TB] FAIL arbitration readies: got %b required 10", {bus.cfg_ready, bus.in_ready}); end
        @(posedge clk); @(negedge clk);
        bus.cfg_valid = 1'b0;
        if (bus.rotor_set) setSeen++;
        nChecks++; if ({bus.rotor_set, bus.in_ready} !== 2'b10) begin nFails++; $display("[TB] FAIL arbitration load cycle: got %b required 10", {bus.rotor_set, bus.in_ready}); end
        refLoad(15'd0, 15'd0);
        exp = refChar(8'h41);
        @(negedge clk);
        if (bus.rotor_set) setSeen++;
        nChecks++; if ({bus.in_ready, bus.configured} !== 2'b11) begin nFails++; $display("[TB] FAIL arbitration char offered: got %b required 11", {bus.in_ready, bus.configured}); end
        @(posedge clk); @(negedge clk);
        bus.in_valid = 1'b0;
        while (!bus.out_valid && n < 20) begin
            if (bus.rotor_set) setSeen++;
            @(negedge clk); n++;
        end
        nChecks++; if (setSeen !== 1) begin nFails++; $display("[TB] FAIL arbitration set pulses: got %0d required 1", setSeen); end
        nChecks++; if (bus.out_valid !== 1'b1 || bus.out_char !== exp) begin nFails++; $display("[TB] FAIL arbitration result: got valid=%b char=%h required valid=1 char=%h", bus.out_valid, bus.out_char, exp); end
        bus.out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_known_vector();
        string expS;
        logic [7:0] m;
        expS = "BDZGO";
        loadCfg(15'd0, 15'd0);
        nChecks++; if (tTimeout !== 0 || tSetCnt !== 1 || tSetAt !== 1) begin nFails++; $display("[TB] FAIL load set pulse: got cnt=%0d at=%0d to=%0d required cnt=1 at=1 to=0", tSetCnt, tSetAt, tTimeout); end
        nChecks++; if (tCfgReadyBack !== 1) begin nFails++; $display("[TB] FAIL load readies at k+2: got %0d required 1", tCfgReadyBack); end
        for (int i = 0; i < 5; i++) begin
            m = refChar(8'h41);
            charTxn(8'h41, 0);
            nChecks++; if (tGot !== expS[i] || tGot !== m || tTimeout !== 0) begin nFails++; $display("[TB] FAIL known vector char %0d: got %h required %h", i, tGot, expS[i]); end
            nChecks++; if (tStepCnt !== 1 || tStepAt !== 1 || tRstepCnt !== 1) begin nFails++; $display("[TB] FAIL known vector step %0d: got cnt=%0d at=%0d step=%0d required 1/1/1", i, tStepCnt, tStepAt, tRstepCnt); end
            nChecks++; if (tOhCnt !== S || tValidAt !== 2 + S || tReadyAfter !== 1) begin nFails++; $display("[TB] FAIL known vector timing %0d: got oh=%0d valid=%0d ready=%0d required %0d/%0d/1", i, tOhCnt, tValidAt, tReadyAfter, S, 2 + S); end
        end
        nChecks++; if (bus.letter_count !== 16'd5 || bus.err !== 1'b0) begin nFails++; $display("[TB] FAIL known vector status: got count=%0d err=%b required 5/0", bus.letter_count, bus.err); end
    endtask

    task automatic test_case_passthrough();
        string inS, expS;
        inS = "a A"; expS = "B D";
        loadCfg(15'd0, 15'd0);
        for (int i = 0; i < 3; i++) begin
            charTxn(inS[i], 0);
            nChecks++; if (tGot !== expS[i] || tTimeout !== 0) begin nFails++; $display("[TB] FAIL case/passthrough char %0d: got %h required %h", i, tGot, expS[i]); end
            if (i == 1) begin
                nChecks++; if (tStepCnt !== 0 || tValidAt !== 1 || tOhCnt !== 0) begin nFails++; $display("[TB] FAIL passthrough timing: got step=%0d valid=%0d oh=%0d required 0/1/0", tStepCnt, tValidAt, tOhCnt); end
            end
        end
        nChecks++; if (bus.letter_count !== 16'd2) begin nFails++; $display("[TB] FAIL case/passthrough count: got %0d required 2", bus.letter_count); end
    endtask

    task automatic test_backpressure();
        logic [7:0] exp;
        loadCfg(15'd0, 15'd0);
        exp = refChar(8'h51);
        charTxn(8'h51, 6);
        nChecks++; if (tGot !== exp || tTimeout !== 0) begin nFails++; $display("[TB] FAIL backpressure char: got %h required %h", tGot, exp); end
        nChecks++; if (tHoldBad !== 0) begin nFails++; $display("[TB] FAIL backpressure output stable: got %0d changes required 0", tHoldBad); end
        nChecks++; if (tHoldReady !== 0 || tHoldSteps !== 0) begin nFails++; $display("[TB] FAIL backpressure quiet: got ready=%0d pulses=%0d required 0/0", tHoldReady, tHoldSteps); end
        nChecks++; if (tReadyAfter !== 1) begin nFails++; $display("[TB] FAIL backpressure release: got in_ready=%0d required 1", tReadyAfter); end
    endtask

    task automatic test_malformed();
        loadCfg(15'd0, 15'd0);
        forceEn = 1'b1; forceVal = 26'd0;
        void'(refChar(8'h41));
        charTxn(8'h41, 0);
        nChecks++; if (tGot !== 8'h3F || bus.err !== 1'b1) begin nFails++; $display("[TB] FAIL malformed zero: got char=%h err=%b required 3f/1", tGot, bus.err); end
        forceVal = 26'h3;
        void'(refChar(8'h43));
        charTxn(8'h43, 0);
        nChecks++; if (tGot !== 8'h3F || bus.err !== 1'b1 || bus.letter_count !== 16'd2) begin nFails++; $display("[TB] FAIL malformed multi: got char=%h err=%b count=%0d required 3f/1/2", tGot, bus.err, bus.letter_count); end
        forceEn = 1'b0;
        loadCfg(15'd5, 15'd0);
        nChecks++; if (bus.err !== 1'b0 || bus.letter_count !== 16'd0) begin nFails++; $display("[TB] FAIL malformed reload clear: got err=%b count=%0d required 0/0", bus.err, bus.letter_count); end
    endtask

    task automatic test_random();
        logic [14:0] off, rg;
        logic [7:0] ch, exp;
        int kind;
        for (int round = 0; round < 3; round++) begin
            off = {5'($urandom_range(0, 25)), 5'($urandom_range(0, 25)), 5'($urandom_range(0, 25))};
            rg  = {5'($urandom_range(0, 25)), 5'($urandom_range(0, 25)), 5'($urandom_range(0, 25))};
            loadCfg(off, rg);
            nChecks++; if (bus.rotor_offset !== off || bus.rotor_ring !== rg) begin nFails++; $display("[TB] FAIL random cfg regs: got %h/%h required %h/%h", bus.rotor_offset, bus.rotor_ring, off, rg); end
            for (int j = 0; j < 12; j++) begin
                kind = int'($urandom_range(0, 3));
                if (kind < 2) ch = 8'(65 + $urandom_range(0, 25));
                else if (kind == 2) ch = 8'(97 + $urandom_range(0, 25));
                else begin
                    ch = 8'($urandom_range(0, 255));
                    if (isAlpha(ch)) ch = 8'h2E;
                end
                exp = refChar(ch);
                charTxn(ch, int'($urandom_range(0, 2)));
                nChecks++; if (tGot !== exp || tTimeout !== 0) begin nFails++; $display("[TB] FAIL random char in=%h: got %h required %h", ch, tGot, exp); end
                nChecks++; if (tValidAt !== (isAlpha(ch) ? 2 + S : 1)) begin nFails++; $display("[TB] FAIL random latency in=%h: got %0d required %0d", ch, tValidAt, isAlpha(ch) ? 2 + S : 1); end
            end
            nChecks++; if (bus.letter_count !== 16'(rCount)) begin nFails++; $display("[TB] FAIL random count: got %0d required %0d", bus.letter_count, rCount); end
        end
    endtask

    task automatic test_reset_mid_settle();
        int n = 0;
        int validSeen = 0;
        int readySeen = 0;
        loadCfg(15'd0, 15'd0);
        bus.in_valid = 1'b1; bus.in_char = 8'h4B;
        while (!bus.in_ready && n < 50) begin @(negedge clk); n++; end
        @(posedge clk); @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        nChecks++; if ((bus.letter_oh != 26'd0) !== 1'b1) begin nFails++; $display("[TB] FAIL mid-settle entry: got letter_oh=%h required nonzero", bus.letter_oh); end
        reset = 1'b1;
        @(posedge clk); @(negedge clk);
        nChecks++; if ({bus.out_valid, bus.configured, bus.in_ready} !== 3'b000 || bus.letter_oh !== 26'd0) begin nFails++; $display("[TB] FAIL mid-settle reset: got v/c/r=%b oh=%h required 000/0", {bus.out_valid, bus.configured, bus.in_ready}, bus.letter_oh); end
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.out_valid) validSeen++;
            if (bus.in_ready) readySeen++;
        end
        nChecks++; if (validSeen !== 0 || readySeen !== 0) begin nFails++; $display("[TB] FAIL mid-settle aftermath: got valid=%0d ready=%0d required 0/0", validSeen, readySeen); end
    endtask

    initial begin
        test_reset();
        test_unconfigured_arbitration();
        test_known_vector();
        test_case_passthrough();
        test_backpressure();
        test_malformed();
        test_random();
        test_reset_mid_settle();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
